// File: rtl/iwrr_arbiter_ctrl_if.sv
// ---------------------------------------------------------------------------
// iwrr_arbiter_ctrl_if
// Bundle of request, weight and grant handshake signals shared between the
// IWRR arbiter controller and its requesters / downstream resource.
//
// Signals:
//   req_i          request vector, bit i belongs to requester i
//   req_weight_i   packed weights, requester n in [n*P_WEIGHT_W +: P_WEIGHT_W]
//                  (ascending range, so requester 0 is the leftmost slice)
//   grant_valid_o  a grant is offered
//   grant_ready_i  downstream accepts the offered grant
//   grant_o        one-hot grant, zero when nothing is offered
//   grant_idx_o    binary index of grant_o
//   round_comp_o   one-cycle pulse when credits are reloaded
//
// Modports:
//   master  the arbiter (drives the grant side)
//   slave   requesters / downstream (drive requests, weights and ready)
// ---------------------------------------------------------------------------
interface iwrr_arbiter_ctrl_if #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 2,
  parameter int P_IDX_W         = $clog2(P_REQUESTER_NUM)
);

  logic [P_REQUESTER_NUM-1:0]            req_i;
  logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_i;
  logic                                  grant_valid_o;
  logic                                  grant_ready_i;
  logic [P_REQUESTER_NUM-1:0]            grant_o;
  logic [P_IDX_W-1:0]                    grant_idx_o;
  logic                                  round_comp_o;

  modport master (
    input  req_i,
    input  req_weight_i,
    input  grant_ready_i,
    output grant_valid_o,
    output grant_o,
    output grant_idx_o,
    output round_comp_o
  );

  modport slave (
    output req_i,
    output req_weight_i,
    output grant_ready_i,
    input  grant_valid_o,
    input  grant_o,
    input  grant_idx_o,
    input  round_comp_o
  );

endinterface

// File: rtl/iwrr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// iwrr_arbiter_ctrl
// Interleaved weighted round-robin arbiter controller. Shares one downstream
// resource among P_REQUESTER_NUM requesters in proportion to their weights,
// issuing one registered one-hot grant at a time over a valid/ready
// handshake. Credits are reloaded from the weights when a round completes and
// round_comp_o pulses for that cycle.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   iwrr_arbiter_ctrl_if.master (requests, weights, grant handshake)
//
// Build option:
//   IWRR_INTERLEAVE_EN  defined   : each requester is served at most once per
//                                   pass, grants interleave between requesters
//                       undefined : plain WRR, a requester keeps winning until
//                                   its credit runs out or its request drops
//
// state | meaning
// ------+---------------------------------------------------------------
// ARB   | choose a winner, start a new pass, reload credits, or idle
// HOLD  | grant offered and held stable until grant_ready_i accepts it
// ---------------------------------------------------------------------------
module iwrr_arbiter_ctrl #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 2,
  parameter int P_IDX_W         = $clog2(P_REQUESTER_NUM)
) (
  input logic                 clk,
  input logic                 rst,
  iwrr_arbiter_ctrl_if.master bus
);

  localparam int N = P_REQUESTER_NUM;

`ifdef IWRR_INTERLEAVE_EN
  // Search starts just past the last winner; reset pointer at N-1 so that
  // requester 0 is looked at first.
  localparam int                 SEARCH_OFS = 1;
  localparam logic [P_IDX_W-1:0] PTR_RST    = P_IDX_W'(N - 1);
`else
  // Search starts at the last winner itself so it can win back-to-back;
  // reset pointer at 0 so that requester 0 is looked at first.
  localparam int                 SEARCH_OFS = 0;
  localparam logic [P_IDX_W-1:0] PTR_RST    = '0;
`endif

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [P_WEIGHT_W-1:0] weight     [N];
  logic [P_WEIGHT_W-1:0] credit     [N];
  logic [P_WEIGHT_W-1:0] credit_nxt [N];
  logic [P_IDX_W-1:0]    ptr;
  logic [P_IDX_W-1:0]    ptr_nxt;
  logic [N-1:0]          grant;
  logic [N-1:0]          grant_nxt;
  logic [P_IDX_W-1:0]    grant_idx;
  logic [P_IDX_W-1:0]    grant_idx_nxt;
  logic                  grant_valid;
  logic                  grant_valid_nxt;
  logic                  round_comp;
  logic                  round_comp_nxt;

  logic [N-1:0]          pending;
  logic [N-1:0]          eligible;
  logic                  win_found;
  logic [P_IDX_W-1:0]    win_idx;
  logic [P_IDX_W-1:0]    search_pos;
  logic                  accept;

`ifdef IWRR_INTERLEAVE_EN
  logic [N-1:0]          served;
  logic [N-1:0]          served_nxt;
`endif

  assign accept = grant_valid & bus.grant_ready_i;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      weight[i]  = bus.req_weight_i[i*P_WEIGHT_W +: P_WEIGHT_W];
      pending[i] = bus.req_i[i] & (credit[i] != '0);
    end
  end

`ifdef IWRR_INTERLEAVE_EN
  assign eligible = pending & ~served;
`else
  assign eligible = pending;
`endif

  // First eligible requester walking upward from ptr+SEARCH_OFS, modulo N.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    search_pos = '0;
    for (int k = 0; k < N; k++) begin
      search_pos = P_IDX_W'((int'(ptr) + SEARCH_OFS + k) % N);
      if (!win_found && eligible[search_pos]) begin
        win_found = 1'b1;
        win_idx   = search_pos;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:  if (win_found) state_nxt = ST_HOLD;
      ST_HOLD: if (accept)    state_nxt = ST_ARB;
      default: state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    credit_nxt      = credit;
    ptr_nxt         = ptr;
    grant_nxt       = grant;
    grant_idx_nxt   = grant_idx;
    grant_valid_nxt = grant_valid;
    round_comp_nxt  = 1'b0;
`ifdef IWRR_INTERLEAVE_EN
    served_nxt      = served;
`endif
    case (state)
      ST_ARB: begin
        if (win_found) begin
          grant_valid_nxt = 1'b1;
          grant_idx_nxt   = win_idx;
          for (int i = 0; i < N; i++) begin
            grant_nxt[i] = (win_idx == P_IDX_W'(i));
          end
`ifdef IWRR_INTERLEAVE_EN
        end else if (pending != '0) begin
          // Everyone with credit left has been served this pass.
          served_nxt = '0;
`endif
        end else if (bus.req_i != '0) begin
          // Requests present but no credit anywhere: the round is complete.
          for (int i = 0; i < N; i++) begin
            credit_nxt[i] = weight[i];
          end
`ifdef IWRR_INTERLEAVE_EN
          served_nxt     = '0;
`endif
          round_comp_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          for (int i = 0; i < N; i++) begin
            if (grant[i] && (credit[i] != '0)) begin
              credit_nxt[i] = credit[i] - P_WEIGHT_W'(1);
            end
          end
`ifdef IWRR_INTERLEAVE_EN
          served_nxt      = served | grant;
`endif
          ptr_nxt         = grant_idx;
          grant_valid_nxt = 1'b0;
          grant_nxt       = '0;
        end
      end
      default: begin
        grant_valid_nxt = 1'b0;
        grant_nxt       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        credit[i] <= '0;
      end
      ptr         <= PTR_RST;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      round_comp  <= 1'b0;
`ifdef IWRR_INTERLEAVE_EN
      served      <= '0;
`endif
    end else begin
      credit      <= credit_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_valid <= grant_valid_nxt;
      round_comp  <= round_comp_nxt;
`ifdef IWRR_INTERLEAVE_EN
      served      <= served_nxt;
`endif
    end
  end

  assign bus.grant_valid_o = grant_valid;
  assign bus.grant_o       = grant;
  assign bus.grant_idx_o   = grant_idx;
  assign bus.round_comp_o  = round_comp;

endmodule

// File: tb/tb_iwrr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iwrr_arbiter_ctrl
// Self-checking bench for iwrr_arbiter_ctrl: a table of directed rounds,
// hand-written corner sequences, and a randomized run, all compared cycle by
// cycle against a behavioural arbiter model held in arrays.
// ---------------------------------------------------------------------------
module tb_iwrr_arbiter_ctrl;

  localparam int N  = 3;
  localparam int W  = 2;
  localparam int IW = 2;

`ifdef IWRR_INTERLEAVE_EN
  localparam bit INTERLEAVE = 1'b1;
`else
  localparam bit INTERLEAVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iwrr_arbiter_ctrl_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W), .P_IDX_W(IW)) bus ();

  iwrr_arbiter_ctrl #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W), .P_IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_credit [N];
  bit m_served [N];
  int m_ptr;
  bit m_gv;
  int m_gidx;
  bit m_rc;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_credit[i] = 0;
      m_served[i] = 1'b0;
    end
    m_ptr  = INTERLEAVE ? N - 1 : 0;
    m_gv   = 1'b0;
    m_gidx = 0;
    m_rc   = 1'b0;
  endtask

  task automatic model_step();
    int w [N];
    int flat;
    int win;
    int i;
    bit any_pend;
    bit pend;
    if (rst) begin
      model_reset();
    end else begin
      flat = int'(bus.req_weight_i);
      for (int n = 0; n < N; n++) w[n] = (flat >> ((N - 1 - n) * W)) % (1 << W);
      m_rc = 1'b0;
      if (m_gv) begin
        if (bus.grant_ready_i) begin
          if (m_credit[m_gidx] > 0) m_credit[m_gidx] = m_credit[m_gidx] - 1;
          m_served[m_gidx] = 1'b1;
          m_ptr = m_gidx;
          m_gv  = 1'b0;
        end
      end else begin
        win = -1;
        any_pend = 1'b0;
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + (INTERLEAVE ? 1 : 0) + k) % N;
          pend = bus.req_i[i] && (m_credit[i] > 0);
          any_pend |= pend;
          if (win < 0 && pend && !(INTERLEAVE && m_served[i])) win = i;
        end
        if (win >= 0) begin
          m_gv   = 1'b1;
          m_gidx = win;
        end else if (any_pend) begin
          for (int n = 0; n < N; n++) m_served[n] = 1'b0;
        end else if (bus.req_i != 0) begin
          for (int n = 0; n < N; n++) begin
            m_credit[n] = w[n];
            m_served[n] = 1'b0;
          end
          m_rc = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("valid", 32'(bus.grant_valid_o), 32'(m_gv));
    check("grant", 32'(bus.grant_o), m_gv ? (32'd1 << m_gidx) : 32'd0);
    check("round_comp", 32'(bus.round_comp_o), 32'(m_rc));
    if (m_gv) check("grant_idx", 32'(bus.grant_idx_o), 32'(m_gidx));
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_w(input int a, input int b, input int c);
    bus.req_weight_i = 6'((a << 4) | (b << 2) | c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.grant_ready_i = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed round table ----------------
  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wt;
    int             n;
    int             seq_il;   // one hex digit per grant, first grant leftmost
    int             seq_wrr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_seq, got, n_g1, n_other, c_prev, gap;
    int g_cyc [3];
    int rc_first, rc_last;
    bit seen_end, found;

    bus.req_i = '0;
    bus.req_weight_i = '0;
    bus.grant_ready_i = 1'b0;
    model_reset();

    tbl[0] = '{3'b111, {2'd2, 2'd1, 2'd3}, 6, 'h012022, 'h001222};
    tbl[1] = '{3'b100, {2'd2, 2'd1, 2'd3}, 3, 'h222,    'h222};
    tbl[2] = '{3'b011, {2'd1, 2'd1, 2'd3}, 2, 'h01,     'h01};
    tbl[3] = '{3'b111, {2'd1, 2'd1, 2'd1}, 3, 'h012,    'h012};
    tbl[4] = '{3'b110, {2'd3, 2'd2, 2'd1}, 3, 'h121,    'h112};
    tbl[5] = '{3'b101, {2'd3, 2'd0, 2'd2}, 5, 'h02020,  'h00022};

    // Reset values while rst is held.
    tick();
    check("rst_valid", 32'(bus.grant_valid_o), 0);
    check("rst_grant", 32'(bus.grant_o), 0);
    check("rst_idx", 32'(bus.grant_idx_o), 0);
    check("rst_round_comp", 32'(bus.round_comp_o), 0);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      bus.req_i = tbl[t].req;
      bus.req_weight_i = tbl[t].wt;
      bus.grant_ready_i = 1'b1;
      exp_seq = INTERLEAVE ? tbl[t].seq_il : tbl[t].seq_wrr;
      got = 0;
      seen_end = 1'b0;
      for (int c = 0; c < 60 && !seen_end; c++) begin
        tick();
        if (bus.grant_valid_o) begin
          if (got < tbl[t].n)
            check("tbl_idx", 32'(bus.grant_idx_o), 32'((exp_seq >> (4 * (tbl[t].n - 1 - got))) & 15));
          got++;
        end
        if (bus.round_comp_o && got > 0) seen_end = 1'b1;
      end
      check("tbl_count", 32'(got), 32'(tbl[t].n));
      check("tbl_reload", 32'(seen_end), 1);
    end

    // Latency after reset: reload, then grant one cycle later.
    do_reset();
    bus.req_i = 3'b111;
    set_w(2, 1, 3);
    bus.grant_ready_i = 1'b1;
    tick();
    check("lat_rc", 32'(bus.round_comp_o), 1);
    check("lat_valid0", 32'(bus.grant_valid_o), 0);
    tick();
    check("lat_valid1", 32'(bus.grant_valid_o), 1);
    check("lat_idx", 32'(bus.grant_idx_o), 0);

    // Backpressure on requester 1 with its request dropped.
    do_reset();
    bus.req_i = 3'b111;
    set_w(2, 1, 3);
    bus.grant_ready_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.grant_valid_o && bus.grant_o == 3'b010) found = 1'b1;
    end
    check("bp_found", 32'(found), 1);
    bus.grant_ready_i = 1'b0;
    bus.req_i = 3'b101;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_grant", 32'(bus.grant_o), 32'h2);
      check("bp_hold_valid", 32'(bus.grant_valid_o), 1);
    end
    bus.grant_ready_i = 1'b1;
    tick();
    check("bp_released", 32'(bus.grant_valid_o), 0);
    bus.req_i = 3'b111;
    n_g1 = 0;
    seen_end = 1'b0;
    for (int c = 0; c < 40 && !seen_end; c++) begin
      tick();
      if (bus.grant_valid_o && bus.grant_o[1]) n_g1++;
      if (bus.round_comp_o) seen_end = 1'b1;
    end
    check("bp_credit_used", 32'(n_g1), 0);
    check("bp_reload", 32'(seen_end), 1);

    // Zero weights: reload every cycle, no grant, until requester 1 joins.
    do_reset();
    set_w(0, 2, 0);
    bus.req_i = 3'b101;
    bus.grant_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("zw_rc_high", 32'(bus.round_comp_o), 1);
      check("zw_no_grant", 32'(bus.grant_valid_o), 0);
    end
    bus.req_i = 3'b111;
    n_g1 = 0;
    n_other = 0;
    seen_end = 1'b0;
    for (int c = 0; c < 30 && !seen_end; c++) begin
      tick();
      if (bus.grant_valid_o) begin
        if (bus.grant_o == 3'b010) n_g1++;
        else n_other++;
      end
      if (bus.round_comp_o && n_g1 > 0) seen_end = 1'b1;
    end
    check("zw_g1_count", 32'(n_g1), 2);
    check("zw_other", 32'(n_other), 0);
    check("zw_reload", 32'(seen_end), 1);

    // Asynchronous reset during an offered grant.
    do_reset();
    bus.req_i = 3'b111;
    set_w(2, 1, 3);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.grant_valid_o) found = 1'b1;
    end
    check("ar_found", 32'(found), 1);
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(bus.grant_valid_o), 0);
    check("ar_grant", 32'(bus.grant_o), 0);
    check("ar_idx", 32'(bus.grant_idx_o), 0);
    check("ar_rc", 32'(bus.round_comp_o), 0);
    model_reset();
    tick();
    rst = 1'b0;
    bus.grant_ready_i = 1'b1;
    tick();
    check("ar_reload", 32'(bus.round_comp_o), 1);
    tick();
    check("ar_first_valid", 32'(bus.grant_valid_o), 1);
    check("ar_first_idx", 32'(bus.grant_idx_o), 0);

    // Sparse: only requester 2 asks.
    do_reset();
    bus.req_i = 3'b100;
    set_w(2, 1, 3);
    bus.grant_ready_i = 1'b1;
    got = 0;
    rc_first = -1;
    rc_last = -1;
    seen_end = 1'b0;
    for (int c = 0; c < 40 && !seen_end; c++) begin
      tick();
      if (bus.grant_valid_o) begin
        check("sp_idx", 32'(bus.grant_idx_o), 2);
        if (got < 3) g_cyc[got] = c;
        got++;
      end
      if (bus.round_comp_o) begin
        if (rc_first < 0) rc_first = c;
        rc_last = c;
        if (got > 0) seen_end = 1'b1;
      end
    end
    check("sp_count", 32'(got), 3);
    check("sp_rc_before", 32'(rc_first >= 0 && rc_first < g_cyc[0]), 1);
    check("sp_rc_after", 32'(seen_end && rc_last > g_cyc[2]), 1);
    gap = INTERLEAVE ? 3 : 2;
    c_prev = g_cyc[0];
    for (int k = 1; k < 3; k++) begin
      check("sp_spacing", 32'(g_cyc[k] - c_prev), 32'(gap));
      c_prev = g_cyc[k];
    end

    // Randomized run against the model.
    do_reset();
    set_w(2, 1, 3);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0)
        set_w(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      bus.grant_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
